// File: rtl/bsg_manycore_profiler_pkg.sv
// Shared types for the remote-load latency profiler: load types, read selects
// and the clear-sequencing FSM states.
package bsg_manycore_profiler_pkg;

    typedef enum logic [1:0] {
        RL_INT     = 2'd0,
        RL_FLOAT   = 2'd1,
        RL_ICACHE  = 2'd2,
        RL_ILLEGAL = 2'd3
    } rl_type_e;

    // Fixed selects; histogram bin k is read at select rl_sel_bin_base_gp + k.
    typedef enum logic [2:0] {
        RL_SEL_COUNT  = 3'd0,
        RL_SEL_SUM_LO = 3'd1,
        RL_SEL_SUM_HI = 3'd2,
        RL_SEL_MAX    = 3'd3,
        RL_SEL_ERR    = 3'd4,
        RL_SEL_OVF    = 3'd5
    } rl_stat_sel_e;

    localparam int rl_num_types_gp    = 3;
    localparam int rl_sel_bin_base_gp = 6;

    typedef enum logic [1:0] {
        RL_ST_IDLE  = 2'd0,
        RL_ST_DRAIN = 2'd1,
        RL_ST_CLEAR = 2'd2
    } rl_state_e;

endpackage

// File: rtl/remote_load_latency_binner.sv
// Latency -> log2 histogram bin: position of the leading one plus one,
// clamped to the last bin. Latency 0 maps to bin 0.
module remote_load_latency_binner #(
    parameter int latency_width_p = 32,
    parameter int hist_bins_p     = 16
) (
    input  logic [latency_width_p-1:0]     i_latency,
    output logic [$clog2(hist_bins_p)-1:0] o_bin
);
    localparam int BIN_W = $clog2(hist_bins_p);

    logic [31:0] w_msb1;

    // Leading-one detect; the highest set bit wins because it is written last.
    always_comb begin
        w_msb1 = '0;
        for (int i = 0; i < latency_width_p; i++) begin
            if (i_latency[i]) w_msb1 = 32'(i + 1);
        end
    end

    assign o_bin = (w_msb1 > 32'(hist_bins_p - 1)) ? BIN_W'(hist_bins_p - 1) : BIN_W'(w_msb1);

endmodule

// File: rtl/remote_load_latency_stats.sv
// Per-type remote-load latency statistics: count, saturating sum with sticky
// overflow, max and a log2 histogram, plus a global illegal-type counter.
// Records flow S1 (register + bin) -> S2 (read-modify-write of the counters).
module remote_load_latency_stats
    import bsg_manycore_profiler_pkg::*;
#(
    parameter int latency_width_p = 32,
    parameter int ctr_width_p     = 32,
    parameter int sum_width_p     = 48,
    parameter int hist_bins_p     = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              v_i,
    output logic                              ready_o,
    input  logic [1:0]                        type_i,
    input  logic [latency_width_p-1:0]        latency_i,
    input  logic                              clear_i,
    input  logic                              rd_v_i,
    input  logic [1:0]                        rd_type_i,
    input  logic [$clog2(hist_bins_p)+2-1:0]  rd_sel_i,
    output logic                              rd_v_o,
    output logic [31:0]                       rd_data_o
);
    localparam int BIN_W = $clog2(hist_bins_p);
    localparam int SEL_W = BIN_W + 2;

    rl_state_e r_state, w_state_nxt;
    logic      w_ready, w_clear_all, w_accept;

    logic                       r_s1_v;
    logic [1:0]                 r_s1_type;
    logic [latency_width_p-1:0] r_s1_lat;
    logic [BIN_W-1:0]           r_s1_bin;
    logic [BIN_W-1:0]           w_bin;

    logic [ctr_width_p-1:0]     r_count [rl_num_types_gp];
    logic [sum_width_p-1:0]     r_sum   [rl_num_types_gp];
    logic [latency_width_p-1:0] r_max   [rl_num_types_gp];
    logic                       r_ovf   [rl_num_types_gp];
    logic [ctr_width_p-1:0]     r_hist  [rl_num_types_gp][hist_bins_p];
    logic [ctr_width_p-1:0]     r_err;

    logic [1:0]                 w_idx;
    logic [sum_width_p:0]       w_sum_ext;

    logic                       r_rd_v;
    logic [31:0]                r_rd_data, w_rd_data;
    logic [1:0]                 w_rd_idx;
    logic [BIN_W-1:0]           w_rd_bin;

    // Ready is forced low while reset is held since the state resets to IDLE.
    assign ready_o  = w_ready & reset_n_i;
    assign w_accept = v_i & ready_o;

    // Clear sequencing state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= RL_ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Clear sequencing: stop intake, let S1/S2 finish, then zero for one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_clear_all = 1'b0;
        case (r_state)
            RL_ST_IDLE: begin
                w_ready = 1'b1;
                if (clear_i) w_state_nxt = RL_ST_DRAIN;
            end
            RL_ST_DRAIN: begin
                if (!r_s1_v) w_state_nxt = RL_ST_CLEAR;
            end
            RL_ST_CLEAR: begin
                w_clear_all = 1'b1;
                w_state_nxt = RL_ST_IDLE;
            end
            default: w_state_nxt = RL_ST_IDLE;
        endcase
    end

    remote_load_latency_binner #(
        .latency_width_p(latency_width_p),
        .hist_bins_p    (hist_bins_p)
    ) u_binner (
        .i_latency(latency_i),
        .o_bin    (w_bin)
    );

    // S1: capture the accepted record with its bin already resolved.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s1_v    <= 1'b0;
            r_s1_type <= '0;
            r_s1_lat  <= '0;
            r_s1_bin  <= '0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_type <= type_i;
                r_s1_lat  <= latency_i;
                r_s1_bin  <= w_bin;
            end
        end
    end

    // S2 operands. The counters update every cycle, so a back-to-back record of
    // the same type always reads the previous record's result with no stall.
    always_comb begin
        w_idx     = (r_s1_type == RL_ILLEGAL) ? 2'd0 : r_s1_type;
        w_sum_ext = {1'b0, r_sum[w_idx]} + (sum_width_p + 1)'(r_s1_lat);
    end

    // S2: read-modify-write of the statistics; CLEAR zeroes them (S1 is empty then).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i || w_clear_all) begin
            for (int t = 0; t < rl_num_types_gp; t++) begin
                r_count[t] <= '0;
                r_sum[t]   <= '0;
                r_max[t]   <= '0;
                r_ovf[t]   <= 1'b0;
                for (int b = 0; b < hist_bins_p; b++) r_hist[t][b] <= '0;
            end
            r_err <= '0;
        end else if (r_s1_v) begin
            if (r_s1_type == RL_ILLEGAL) begin
                if (r_err != '1) r_err <= r_err + ctr_width_p'(1);
            end else begin
                if (r_count[w_idx] != '1)
                    r_count[w_idx] <= r_count[w_idx] + ctr_width_p'(1);
                if (r_hist[w_idx][r_s1_bin] != '1)
                    r_hist[w_idx][r_s1_bin] <= r_hist[w_idx][r_s1_bin] + ctr_width_p'(1);
                if (w_sum_ext[sum_width_p]) begin
                    r_sum[w_idx] <= '1;
                    r_ovf[w_idx] <= 1'b1;
                end else begin
                    r_sum[w_idx] <= w_sum_ext[sum_width_p-1:0];
                end
                if (r_s1_lat > r_max[w_idx]) r_max[w_idx] <= r_s1_lat;
            end
        end
    end

    // Read mux over the current (pre-update) counter values; err is global.
    always_comb begin
        w_rd_data = '0;
        w_rd_idx  = (rd_type_i == RL_ILLEGAL) ? 2'd0 : rd_type_i;
        w_rd_bin  = BIN_W'(rd_sel_i - SEL_W'(rl_sel_bin_base_gp));
        if (rd_sel_i == SEL_W'(RL_SEL_ERR)) begin
            w_rd_data = 32'(r_err);
        end else if (rd_type_i != RL_ILLEGAL) begin
            if (int'(rd_sel_i) >= rl_sel_bin_base_gp &&
                int'(rd_sel_i) <  rl_sel_bin_base_gp + hist_bins_p) begin
                w_rd_data = 32'(r_hist[w_rd_idx][w_rd_bin]);
            end else begin
                case (rd_sel_i)
                    SEL_W'(RL_SEL_COUNT):  w_rd_data = 32'(r_count[w_rd_idx]);
                    SEL_W'(RL_SEL_SUM_LO): w_rd_data = 32'(r_sum[w_rd_idx]);
                    SEL_W'(RL_SEL_SUM_HI): w_rd_data = 32'(r_sum[w_rd_idx] >> 32);
                    SEL_W'(RL_SEL_MAX):    w_rd_data = 32'(r_max[w_rd_idx]);
                    SEL_W'(RL_SEL_OVF):    w_rd_data = 32'(r_ovf[w_rd_idx]);
                    default:               w_rd_data = '0;
                endcase
            end
        end
    end

    // Registered read response, one cycle after the request.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_v    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_v <= rd_v_i;
            if (rd_v_i) r_rd_data <= w_rd_data;
        end
    end

    assign rd_v_o    = r_rd_v;
    assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_remote_load_latency_stats.sv
// Scoreboard bench: every read pushes its expected value; a negedge monitor
// pops and compares whenever rd_v_o is presented. sum_width_p is reduced to 34
// so the sum saturation point is reachable with a handful of records.
module tb_remote_load_latency_stats;
    localparam int LW = 32, CW = 32, SW = 34, HB = 16, SELW = 6;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            v_i = 1'b0, clear_i = 1'b0, rd_v_i = 1'b0;
    logic [1:0]      type_i = '0, rd_type_i = '0;
    logic [LW-1:0]   latency_i = '0;
    logic [SELW-1:0] rd_sel_i = '0;
    logic            ready_o, rd_v_o;
    logic [31:0]     rd_data_o;

    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    remote_load_latency_stats #(
        .latency_width_p(LW), .ctr_width_p(CW), .sum_width_p(SW), .hist_bins_p(HB)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .ready_o(ready_o),
        .type_i(type_i), .latency_i(latency_i), .clear_i(clear_i),
        .rd_v_i(rd_v_i), .rd_type_i(rd_type_i), .rd_sel_i(rd_sel_i),
        .rd_v_o(rd_v_o), .rd_data_o(rd_data_o)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic rd_set(input logic [1:0] t, input int sel, input logic [31:0] exp, input string nm);
        rd_v_i    = 1'b1;
        rd_type_i = t;
        rd_sel_i  = SELW'(sel);
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic rd(input logic [1:0] t, input int sel, input logic [31:0] exp, input string nm);
        rd_set(t, sel, exp, nm);
        step();
        rd_v_i = 1'b0;
    endtask

    task automatic rec(input logic [1:0] t, input logic [31:0] lat);
        chk("ready_before_rec", 32'(ready_o), 32'd1);
        v_i = 1'b1; type_i = t; latency_i = lat;
        step();
        v_i = 1'b0;
    endtask

    // Monitor: each read response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rd_v_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got %0h want no response", rd_data_o);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string       n = name_q.pop_front();
                if (rd_data_o !== e) begin
                    errors++;
                    $display("FAIL %s got %0h want %0h", n, rd_data_o, e);
                end
            end
        end
    end

    initial begin
        int n;
        int sels[5] = '{0, 1, 3, 5, 4};

        // 1: reset state, then release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_rd_v", 32'(rd_v_o), 32'd0);
        chk("rst_rd_data", rd_data_o, 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("ready_after_release", 32'(ready_o), 32'd1);
        step();
        for (int t = 0; t < 4; t++)
            for (int s = 0; s < 5; s++)
                rd(2'(t), sels[s], 32'd0, $sformatf("t1_zero_t%0d_s%0d", t, sels[s]));

        // 2: int records back-to-back
        rec(2'd0, 32'd0); rec(2'd0, 32'd1); rec(2'd0, 32'd5); rec(2'd0, 32'd100);
        step();
        rd(2'd0, 0, 32'd4, "t2_count");
        rd(2'd0, 1, 32'd106, "t2_sum_lo");
        rd(2'd0, 2, 32'd0, "t2_sum_hi");
        rd(2'd0, 3, 32'd100, "t2_max");
        rd(2'd0, 6, 32'd1, "t2_bin0");
        rd(2'd0, 7, 32'd1, "t2_bin1");
        rd(2'd0, 8, 32'd0, "t2_bin2");
        rd(2'd0, 9, 32'd1, "t2_bin3");
        rd(2'd0, 13, 32'd1, "t2_bin7");
        rd(2'd0, 5, 32'd0, "t2_ovf");

        // 3: float latency 2^31 clamps into the last bin
        rec(2'd1, 32'h8000_0000);
        step();
        rd(2'd1, 21, 32'd1, "t3_bin15");
        rd(2'd1, 20, 32'd0, "t3_bin14");
        rd(2'd1, 3, 32'h8000_0000, "t3_max");
        rd(2'd1, 0, 32'd1, "t3_count");
        rd(2'd0, 0, 32'd4, "t3_int_count");
        rd(2'd0, 3, 32'd100, "t3_int_max");

        // 4: icache sum up to 2^34-4, then saturate
        repeat (4) rec(2'd2, 32'hFFFF_FFFF);
        step();
        rd(2'd2, 1, 32'hFFFF_FFFC, "t4_pre_sum_lo");
        rd(2'd2, 2, 32'd3, "t4_pre_sum_hi");
        rd(2'd2, 5, 32'd0, "t4_pre_ovf");
        rec(2'd2, 32'd20);
        step();
        rd(2'd2, 1, 32'hFFFF_FFFF, "t4_sat_sum_lo");
        rd(2'd2, 2, 32'd3, "t4_sat_sum_hi");
        rd(2'd2, 5, 32'd1, "t4_ovf");
        rd(2'd2, 0, 32'd5, "t4_count");
        rd(2'd2, 3, 32'hFFFF_FFFF, "t4_max");
        rd(2'd2, 21, 32'd4, "t4_bin15");
        rd(2'd2, 11, 32'd1, "t4_bin5");

        // 5: clear together with an accepted record
        chk("t5_ready_idle", 32'(ready_o), 32'd1);
        v_i = 1'b1; type_i = 2'd0; latency_i = 32'd7; clear_i = 1'b1;
        step();
        v_i = 1'b0; clear_i = 1'b0;
        chk("t5_ready_drain0", 32'(ready_o), 32'd0);
        step();
        chk("t5_ready_drain1", 32'(ready_o), 32'd0);
        rd_set(2'd0, 0, 32'd5, "t5_count_inflight");
        step();
        rd_v_i = 1'b0;
        chk("t5_ready_clear", 32'(ready_o), 32'd0);
        rd_set(2'd2, 5, 32'd1, "t5_ovf_preclear");
        step();
        rd_v_i = 1'b0;
        n = 0;
        while (ready_o !== 1'b1 && n < 8) begin step(); n++; end
        chk("t5_ready_back", 32'(ready_o), 32'd1);
        rd(2'd0, 0, 32'd0, "t5_int_count");
        rd(2'd0, 9, 32'd0, "t5_int_bin3");
        rd(2'd2, 5, 32'd0, "t5_icache_ovf");
        rd(2'd2, 1, 32'd0, "t5_icache_sum_lo");
        rd(2'd2, 2, 32'd0, "t5_icache_sum_hi");
        rd(2'd1, 21, 32'd0, "t5_float_bin15");
        rd(2'd1, 3, 32'd0, "t5_float_max");

        // 6: illegal type with a same-cycle read of int count
        rec(2'd0, 32'd3);
        step();
        chk("t6_ready", 32'(ready_o), 32'd1);
        v_i = 1'b1; type_i = 2'd3; latency_i = 32'd50;
        rd_set(2'd0, 0, 32'd1, "t6_count_same_cycle");
        step();
        v_i = 1'b0; rd_v_i = 1'b0;
        step();
        rd(2'd3, 4, 32'd1, "t6_err_t3");
        rd(2'd0, 4, 32'd1, "t6_err_t0");
        rd(2'd0, 0, 32'd1, "t6_int_count");
        rd(2'd0, 8, 32'd1, "t6_int_bin2");
        rd(2'd0, 12, 32'd0, "t6_int_bin6");
        rd(2'd3, 0, 32'd0, "t6_t3_count");
        rd(2'd3, 3, 32'd0, "t6_t3_max");
        rd(2'd0, 30, 32'd0, "t6_sel_oor");
        rd(2'd0, 63, 32'd0, "t6_sel_max");

        // Reset mid-operation drops the in-flight record
        rec(2'd0, 32'd9);
        rst_n = 1'b0;
        #2 chk("midrst_ready", 32'(ready_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        rd(2'd0, 0, 32'd0, "midrst_count");
        rd(2'd3, 4, 32'd0, "midrst_err");

        repeat (3) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
